// File: rtl/imem_boot_loader.sv
// Boot loader: streams 32-bit words into a byte-wide instruction memory,
// big-endian, from address 0, holding the core stalled while loading.
//
// state | meaning
// IDLE  | waiting for start, core free to run
// LOAD  | ready for the next word from the boot source
// WRITE | emitting the latched word as four byte writes
// DONE  | load finished (error set if a word did not fit), core released
module imem_boot_loader #(
    parameter int unsigned MEM_BYTES = 100,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_stall,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] byte_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [1:0]        idx;
    logic [31:0]       data_q;
    logic              last_q;
    logic              error_q;
    logic              in_ready_q;
    logic [ADDR_W-1:0] byte_count_q;
    logic              word_fits;

    // One extra bit so a pointer near the top of the address space cannot wrap.
    assign word_fits = ({1'b0, ptr} + (ADDR_W+1)'(4)) <= MEM_LIMIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (in_valid) state_nxt = word_fits ? S_WRITE : S_DONE;
            end
            S_WRITE: begin
                if (idx == 2'd3) state_nxt = last_q ? S_DONE : S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        cpu_stall = (state == S_LOAD) || (state == S_WRITE);
        done      = (state == S_DONE);
        if (state == S_WRITE) begin
            mem_we   = 1'b1;
            mem_addr = ptr + ADDR_W'(idx);
            case (idx)
                2'd0:    mem_wdata = data_q[31:24];
                2'd1:    mem_wdata = data_q[23:16];
                2'd2:    mem_wdata = data_q[15:8];
                default: mem_wdata = data_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            idx          <= 2'd0;
            data_q       <= 32'h0;
            last_q       <= 1'b0;
            error_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            in_ready_q <= (state_nxt == S_LOAD);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ptr          <= '0;
                        idx          <= 2'd0;
                        error_q      <= 1'b0;
                        byte_count_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        last_q <= in_last;
                        idx    <= 2'd0;
                        if (!word_fits) error_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    byte_count_q <= byte_count_q + ADDR_W'(1);
                    idx          <= idx + 2'd1;
                    if (idx == 2'd3) ptr <= ptr + ADDR_W'(4);
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign error      = error_q;
    assign byte_count = byte_count_q;

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Sequential loader that fills the byte-wide instruction memory from a 32-bit word stream before the core runs. Each accepted word is written as four consecutive big-endian byte writes starting at address 0, matching the fetch order `{mem[a], mem[a+1], mem[a+2], mem[a+3]}`. The loader holds the core in stall while loading and reports completion or overflow. It sits between the test/boot source and the instruction memory write port; the core's fetch path is unchanged.

## Interface
- `MEM_BYTES`, default 100: instruction memory depth in bytes.
- `ADDR_W`, default 32: width of the byte address.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: pulse that begins a load; honoured only in IDLE or DONE.
- `in_valid`, input, 1: source has a word on `in_data`.
- `in_data`, input, 32: instruction word.
- `in_last`, input, 1: qualifies the final word of the program; sampled with the handshake.
- `in_ready`, output, 1: loader can accept a word; registered.
- `mem_we`, output, 1: byte write strobe to the instruction memory.
- `mem_addr`, output, ADDR_W: byte address for the write.
- `mem_wdata`, output, 8: byte to write.
- `cpu_stall`, output, 1: holds the core's PC and fetch while loading.
- `done`, output, 1: load finished; held until the next `start` or `rst`.
- `error`, output, 1: a word was dropped because it did not fit; held with `done`.
- `byte_count`, output, ADDR_W: number of bytes written in the current or last load.

## Operation
- States:
  - **IDLE**: `in_ready=0`, `cpu_stall=0`. On `start`, go to LOAD, clear `byte_count`, `done` and `error`, and set the write pointer to 0.
  - **LOAD**: `in_ready=1`, `cpu_stall=1`. A handshake occurs on a cycle where `in_valid & in_ready`. On handshake, latch `in_data` and `in_last`.
    - If `ptr + 4 > MEM_BYTES`, drop the word, set `error=1` and go to DONE.
    - Otherwise go to WRITE with byte index 0.
    - Without a handshake, stay in LOAD with no writes.
  - **WRITE**: `in_ready=0`, `cpu_stall=1`. One byte is written per cycle for index 0..3.
    - `mem_we=1`, `mem_addr=ptr+index`.
    - `mem_wdata` is `data[31:24]`, `[23:16]`, `[15:8]`, `[7:0]` for index 0, 1, 2, 3 respectively.
    - `byte_count` increments once per written byte.
    - After index 3, `ptr += 4`. If the latched `last` is set, go to DONE; otherwise return to LOAD.
  - **DONE**: `in_ready=0`, `cpu_stall=0`, `done=1`. On `start`, restart exactly as from IDLE.
- `start` is ignored in LOAD and WRITE.
- `in_valid` is ignored outside LOAD, and `in_data` is not sampled there.
- Address arithmetic is unsigned ADDR_W. The overflow check uses `ptr + 4 > MEM_BYTES`, computed without wrap (one extra bit).
- `mem_addr` and `mem_wdata` outside WRITE are 0.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - `cpu_stall=0`, `done=0`, `error=0`, `byte_count=0`.
- `start` is sampled in cycle N. LOAD is entered and `in_ready=1` and `cpu_stall=1` are visible in cycle N+1.
- A handshake in cycle H produces:
  - Byte writes in cycles H+1..H+4, with `in_ready=0` in those cycles.
  - `in_ready=1` again in cycle H+5 when the loader returns to LOAD.
  - Sustained throughput of 1 word per 5 cycles.
- Last word handshaken in cycle H: `done=1` and `cpu_stall=0` in cycle H+5.
- Overflowing handshake in cycle H: `done=1`, `error=1` and `cpu_stall=0` in cycle H+1, with no write.
- `rst` asserted mid-WRITE:
  - Next cycle is IDLE with all outputs at reset values and no further `mem_we`.
  - Bytes already written stay in memory; they are not rolled back.
- `rst` and `start` asserted together: `rst` wins.
- A `start` arriving in the same cycle as the DONE entry condition is ignored, because the loader is still busy in that cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles → every output is 0 and the state is IDLE. `in_valid=1` while in IDLE → `in_ready` stays 0 and there are no writes.
- **Two-word load:** `start`, then 0x00500093 and then 0x00A00113 with `in_last` on the second.
  - Writes 00,50,00,93,00,A0,01,13 to addresses 0..7.
  - `byte_count=8`, `done=1`, `cpu_stall=0`.
  - Instruction memory fetch at 0 returns 0x00500093 and at 4 returns 0x00A00113.
- **Source gaps:** drop `in_valid` for 3 cycles between words → the loader stays in LOAD, `mem_we=0` throughout, and the second word lands at address 4.
- **Overflow:** with `MEM_BYTES=8`, send 3 words with no `in_last`.
  - Bytes 0..7 are written and the third word is dropped.
  - `error=1` and `done=1` one cycle after the third handshake; no write at address 8.
- **Mid-operation reset:** `rst` after the second byte of a word → no `mem_we` from the next cycle and everything at reset values. A following `start` reloads from address 0.
- **Start handling:** `start` pulsed during WRITE → ignored and the load completes normally. `start` in DONE → `done` and `error` clear, `byte_count=0`, `in_ready=1` the next cycle.
